kosei_i2s_rx: RTL and testbench

I2S receiver that deserializes the external `i2s_bclk`/`i2s_lrclk`/`i2s_data` stream into parallel signed left/right PCM sample pairs. It oversamples the three pins in the master-clock domain and checks frame length. It presents each sample pair on a one-deep valid/ready output toward the input selector and DSP chain. It also reports link lock and error status for `audio_present` and `diagnostic_data`.

---
 rtl/kosei_i2s_pkg.sv | 17 +
 rtl/kosei_sync_edge.sv | 38 +++
 rtl/kosei_i2s_rx.sv | 210 +++++++++++++++++++++
 tb/tb_kosei_i2s_rx.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kosei_i2s_pkg.sv
// kosei_i2s_pkg
//   Shared constants and types for the kosei I2S receiver.
//   I2S_DATA_W     : default PCM sample width
//   I2S_SLOT_W     : default BCLK rises per channel slot
//   i2s_rx_state_t : receiver framing state (HUNT, LEFT, RIGHT)
package kosei_i2s_pkg;

  localparam int I2S_DATA_W = 24;
  localparam int I2S_SLOT_W = 32;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_rx_state_t;

endpackage

// File: rtl/kosei_sync_edge.sv
// kosei_sync_edge
//   Two-flop synchronizer for an asynchronous pin plus a rising-edge
//   detector on the synchronized value.
//   clk  in  : sampling clock
//   rst  in  : synchronous active-high reset
//   pin  in  : asynchronous input
//   sync out : synchronized pin value
//   rise out : one-cycle strobe when sync goes 0->1
module kosei_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic rise
);

  logic meta;
  logic stable;
  logic prev;

  // NOTE: flops use non-blocking assignments so each stage samples the
  // previous stage's old value; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= 1'b0;
      stable <= 1'b0;
      prev   <= 1'b0;
    end else begin
      meta   <= pin;
      stable <= meta;
      prev   <= stable;
    end
  end

  assign sync = stable;
  assign rise = stable & ~prev;

endmodule

// File: rtl/kosei_i2s_rx.sv
// kosei_i2s_rx
//   Philips-format I2S receiver. Oversamples BCLK/LRCLK/DATA in the
//   clk_mclk domain, checks slot lengths, and presents signed left/right
//   sample pairs on a one-deep valid/ready buffer.
//   Optional macro KOSEI_I2S_RX_STATS_EN adds stat_frames/stat_errors.
// Ports:
//   clk_mclk, rst                 : master clock, sync active-high reset
//   i2s_bclk, i2s_lrclk, i2s_data : asynchronous I2S pins
//   out_left, out_right           : received sample pair
//   out_valid / out_ready         : sample-pair handshake
//   rx_locked                     : LOCK_FRAMES consecutive good frames seen
//   frame_error                   : one-cycle pulse per bad slot
//   overrun                       : sticky, a held pair was overwritten
//   stat_frames, stat_errors      : (stats build) wrapping event counters
module kosei_i2s_rx
  import kosei_i2s_pkg::*;
#(
  parameter int DATA_W      = I2S_DATA_W,
  parameter int SLOT_W      = I2S_SLOT_W,
  parameter int LOCK_FRAMES = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_mclk,
  input  logic              rst,
  input  logic              i2s_bclk,
  input  logic              i2s_lrclk,
  input  logic              i2s_data,
  output logic [DATA_W-1:0] out_left,
  output logic [DATA_W-1:0] out_right,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              rx_locked,
  output logic              frame_error,
  output logic              overrun
`ifdef KOSEI_I2S_RX_STATS_EN
  ,
  output logic [15:0]       stat_frames,
  output logic [15:0]       stat_errors
`endif
);

  localparam int K_W    = $clog2(SLOT_W + 1);
  localparam int LOCK_W = $clog2(LOCK_FRAMES + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYC);

  // BCLK needs the edge detector; LRCLK and DATA only need synchronizing.
  logic       bclk_sync;
  logic       bclk_rise;
  logic [1:0] pin_meta;
  logic [1:0] pin_sync;
  logic       lrclk_sync;
  logic       data_sync;

  kosei_sync_edge u_bclk_sync (
    .clk  (clk_mclk),
    .rst  (rst),
    .pin  (i2s_bclk),
    .sync (bclk_sync),
    .rise (bclk_rise)
  );

  always_ff @(posedge clk_mclk) begin
    if (rst) begin
      pin_meta <= '0;
      pin_sync <= '0;
    end else begin
      pin_meta <= {i2s_lrclk, i2s_data};
      pin_sync <= pin_meta;
    end
  end

  assign lrclk_sync = pin_sync[1];
  assign data_sync  = pin_sync[0];

  i2s_rx_state_t     state;
  logic [K_W-1:0]    k;
  logic [K_W-1:0]    k_next;
  logic              lr_prev;
  logic [DATA_W-1:0] shift_l;
  logic [DATA_W-1:0] shift_r;
  logic              left_ok;
  logic [LOCK_W-1:0] good_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic lr_fall;
  logic lr_rise;
  logic slot_full;
  logic shift_en;
  logic timeout;
  logic end_left;
  logic end_right;
  logic slot_bad;
  logic pair_load;

  assign lr_fall   = lr_prev & ~lrclk_sync;
  assign lr_rise   = ~lr_prev & lrclk_sync;
  // The transition rise is k=0 of the new slot, so a full slot ends with
  // the previous rise at k=SLOT_W-1.
  assign slot_full = (k == K_W'(SLOT_W - 1));
  assign k_next    = (k == K_W'(SLOT_W)) ? k : k + K_W'(1);
  // k=0 carries the previous channel's LSB (one-bit delay); only
  // k=1..DATA_W are sample bits.
  assign shift_en  = (k_next <= K_W'(DATA_W));
  assign timeout   = !bclk_rise && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign end_left  = bclk_rise && (state == LEFT) && lr_rise;
  assign end_right = bclk_rise && (state == RIGHT) && lr_fall;
  assign slot_bad  = (end_left || end_right) && !slot_full;
  assign pair_load = end_right && slot_full && left_ok;

  always_ff @(posedge clk_mclk) begin
    if (rst) begin
      state       <= HUNT;
      k           <= '0;
      lr_prev     <= 1'b0;
      shift_l     <= '0;
      shift_r     <= '0;
      left_ok     <= 1'b0;
      good_cnt    <= '0;
      to_cnt      <= '0;
      frame_error <= 1'b0;
    end else begin
      // NOTE: the pulse is rewritten every cycle, so it self-clears
      // without any separate clear logic.
      frame_error <= slot_bad;

      if (bclk_rise || timeout) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_W'(1);
      end

      if (timeout) begin
        // Link loss is not a framing error: just drop back and re-hunt.
        state    <= HUNT;
        good_cnt <= '0;
      end else if (bclk_rise) begin
        lr_prev <= lrclk_sync;
        case (state)
          HUNT: begin
            if (lr_fall) begin
              state <= LEFT;
              k     <= '0;
            end
          end
          LEFT: begin
            if (lr_rise) begin
              state   <= RIGHT;
              k       <= '0;
              left_ok <= slot_full;
            end else begin
              k <= k_next;
              if (shift_en) shift_l <= {shift_l[DATA_W-2:0], data_sync};
            end
          end
          RIGHT: begin
            if (lr_fall) begin
              state <= LEFT;
              k     <= '0;
            end else begin
              k <= k_next;
              if (shift_en) shift_r <= {shift_r[DATA_W-2:0], data_sync};
            end
          end
          default: state <= HUNT;
        endcase

        if (slot_bad) begin
          good_cnt <= '0;
        end else if (pair_load && (good_cnt != LOCK_W'(LOCK_FRAMES))) begin
          good_cnt <= good_cnt + LOCK_W'(1);
        end
      end
    end
  end

  // Lock is a pure decode of the counter, so it rises in the same cycle
  // as out_valid for the LOCK_FRAMES-th good pair.
  assign rx_locked = (good_cnt == LOCK_W'(LOCK_FRAMES));

  always_ff @(posedge clk_mclk) begin
    if (rst) begin
      out_left  <= '0;
      out_right <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (pair_load) begin
      // A simultaneous handshake consumes the old pair, so only an
      // unaccepted held pair counts as overrun.
      out_left  <= shift_l;
      out_right <= shift_r;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) overrun <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef KOSEI_I2S_RX_STATS_EN
  always_ff @(posedge clk_mclk) begin
    if (rst) begin
      stat_frames <= '0;
      stat_errors <= '0;
    end else begin
      if (pair_load) stat_frames <= stat_frames + 16'd1;
      if (frame_error) stat_errors <= stat_errors + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kosei_i2s_rx.sv
// tb_kosei_i2s_rx
//   Randomized self-checking bench for kosei_i2s_rx. Frames are generated
//   as lists of (left, right, left rises, right rises); the reference model
//   derives expected pairs, lock state and error counts from those lists.
module tb_kosei_i2s_rx;

  localparam int DATA_W      = 24;
  localparam int SLOT_W      = 32;
  localparam int LOCK_FRAMES = 4;
  localparam int TIMEOUT_CYC = 64;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    int                nl;
    int                nr;
  } frame_t;

  typedef struct {
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    logic              locked;
  } pair_t;

  logic              clk_mclk = 1'b0;
  logic              rst = 1'b1;
  logic              i2s_bclk = 1'b0;
  logic              i2s_lrclk = 1'b0;
  logic              i2s_data = 1'b0;
  logic [DATA_W-1:0] out_left;
  logic [DATA_W-1:0] out_right;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              rx_locked;
  logic              frame_error;
  logic              overrun;
`ifdef KOSEI_I2S_RX_STATS_EN
  logic [15:0]       stat_frames;
  logic [15:0]       stat_errors;
`endif

  kosei_i2s_rx #(
    .DATA_W      (DATA_W),
    .SLOT_W      (SLOT_W),
    .LOCK_FRAMES (LOCK_FRAMES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk_mclk    (clk_mclk),
    .rst         (rst),
    .i2s_bclk    (i2s_bclk),
    .i2s_lrclk   (i2s_lrclk),
    .i2s_data    (i2s_data),
    .out_left    (out_left),
    .out_right   (out_right),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .rx_locked   (rx_locked),
    .frame_error (frame_error),
    .overrun     (overrun)
`ifdef KOSEI_I2S_RX_STATS_EN
    ,
    .stat_frames (stat_frames),
    .stat_errors (stat_errors)
`endif
  );

  always #5 clk_mclk = ~clk_mclk;

  int     n_vec = 0;
  int     n_err = 0;
  int     err_pulses = 0;
  int     exp_errs = 0;
  int     exp_good = 0;
  int     streak = 0;
  pair_t  got_q[$];
  pair_t  exp_q[$];
  frame_t plan[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Record every accepted pair and every error-pulse cycle.
  always @(negedge clk_mclk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back('{out_left, out_right, rx_locked});
      if (frame_error) err_pulses++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_mclk);
    #2;
  endtask

  // One BCLK period = 4 clk_mclk cycles; LRCLK/DATA change with BCLK fall.
  task automatic send_bit(input logic lr, input logic d);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_data  = d;
    tick(2);
    i2s_bclk = 1'b1;
    tick(2);
  endtask

  // Rise 0 carries the previous channel's LSB, rises 1..DATA_W the sample
  // MSB first, the rest is padding; non-sample bits are random noise.
  task automatic send_slot(input logic lr, input logic [DATA_W-1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      logic b;
      if (i >= 1 && i <= DATA_W) b = s[DATA_W-i];
      else b = 1'($urandom());
      send_bit(lr, b);
    end
  endtask

  task automatic preamble();
    repeat (4) send_bit(1'b1, 1'($urandom()));
  endtask

  // Start of the next left slot closes the last right slot.
  task automatic tail();
    send_bit(1'b0, 1'($urandom()));
    tick(8);
  endtask

  task automatic clear_model();
    got_q.delete();
    exp_q.delete();
    plan.delete();
    err_pulses = 0;
    exp_errs   = 0;
    exp_good   = 0;
    streak     = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    clear_model();
  endtask

  function automatic frame_t rand_frame(input int nl, input int nr);
    frame_t f;
    f.l  = DATA_W'($urandom());
    f.r  = DATA_W'($urandom());
    f.nl = nl;
    f.nr = nr;
    return f;
  endfunction

  function automatic int rand_len();
    int c;
    c = int'($urandom_range(0, 9));
    if (c == 0) return SLOT_W - 1;
    if (c == 1) return SLOT_W + 1;
    return SLOT_W;
  endfunction

  // Reference model: a frame yields a pair only if both slots are exactly
  // SLOT_W long; each wrong-length slot is one error and breaks the streak.
  task automatic play_plan();
    foreach (plan[i]) begin
      send_slot(1'b0, plan[i].l, plan[i].nl);
      send_slot(1'b1, plan[i].r, plan[i].nr);
      if (plan[i].nl != SLOT_W) begin exp_errs++; streak = 0; end
      if (plan[i].nr != SLOT_W) begin exp_errs++; streak = 0; end
      if (plan[i].nl == SLOT_W && plan[i].nr == SLOT_W) begin
        if (streak < LOCK_FRAMES) streak++;
        exp_good++;
        exp_q.push_back('{plan[i].l, plan[i].r, (streak == LOCK_FRAMES)});
      end
    end
  endtask

  task automatic compare_pairs(input string tag);
    int n;
    check({tag, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_left%0d", tag, i), 32'(got_q[i].l), 32'(exp_q[i].l));
      check($sformatf("%s_right%0d", tag, i), 32'(got_q[i].r), 32'(exp_q[i].r));
      check($sformatf("%s_lock%0d", tag, i), 32'(got_q[i].locked), 32'(exp_q[i].locked));
    end
    check({tag, "_errors"}, err_pulses, exp_errs);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_left"}, 32'(out_left), 0);
    check({tag, "_right"}, 32'(out_right), 0);
    check({tag, "_valid"}, 32'(out_valid), 0);
    check({tag, "_locked"}, 32'(rx_locked), 0);
    check({tag, "_ferr"}, 32'(frame_error), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    frame_t a;
    frame_t b;

    // Reset state
    do_reset();
    check_zero_outputs("rst");

    // Six fixed full-scale frames, lock with the fourth pair
    do_reset();
    out_ready = 1'b1;
    preamble();
    repeat (6) plan.push_back('{24'h7FFFFF, 24'h800001, SLOT_W, SLOT_W});
    play_plan();
    tail();
    compare_pairs("fixed");
    check("fixed_locked_end", 32'(rx_locked), 1);

    // Short left slot in frame 3, relock on the fourth good frame after
    do_reset();
    out_ready = 1'b1;
    preamble();
    for (int i = 0; i < 8; i++) plan.push_back(rand_frame((i == 2) ? SLOT_W - 1 : SLOT_W, SLOT_W));
    play_plan();
    tail();
    compare_pairs("short");
    check("short_locked_end", 32'(rx_locked), 1);

    // Random slot lengths
    do_reset();
    out_ready = 1'b1;
    preamble();
    for (int i = 0; i < 12; i++) plan.push_back(rand_frame(rand_len(), rand_len()));
    play_plan();
    tail();
    compare_pairs("rlen");
    check("rlen_locked_end", 32'(rx_locked), 32'(streak == LOCK_FRAMES));

    // Overrun: two pairs with no consumer, then drain
    do_reset();
    out_ready = 1'b0;
    preamble();
    a = rand_frame(SLOT_W, SLOT_W);
    b = rand_frame(SLOT_W, SLOT_W);
    plan.push_back(a);
    plan.push_back(b);
    play_plan();
    tail();
    check("ovr_taken_none", got_q.size(), 0);
    check("ovr_valid", 32'(out_valid), 1);
    check("ovr_left_held", 32'(out_left), 32'(b.l));
    check("ovr_right_held", 32'(out_right), 32'(b.r));
    check("ovr_flag", 32'(overrun), 1);
    out_ready = 1'b1;
    tick(4);
    check("ovr_taken_one", got_q.size(), 1);
    if (got_q.size() > 0) begin
      check("ovr_got_left", 32'(got_q[0].l), 32'(b.l));
      check("ovr_got_right", 32'(got_q[0].r), 32'(b.r));
    end
    check("ovr_valid_drop", 32'(out_valid), 0);
    check("ovr_sticky", 32'(overrun), 1);

    // BCLK stall while locked, resume mid-right-slot
    do_reset();
    out_ready = 1'b1;
    preamble();
    repeat (5) plan.push_back(rand_frame(SLOT_W, SLOT_W));
    play_plan();
    tail();
    compare_pairs("to_pre");
    check("to_locked_before", 32'(rx_locked), 1);
    tick(TIMEOUT_CYC + 6);
    check("to_unlocked", 32'(rx_locked), 0);
    clear_model();
    repeat (10) send_bit(1'b1, 1'($urandom()));
    plan.push_back(rand_frame(SLOT_W, SLOT_W));
    play_plan();
    tail();
    compare_pairs("to_post");

    // Reset at k=12 of a left slot
    do_reset();
    out_ready = 1'b0;
    preamble();
    repeat (5) plan.push_back(rand_frame(SLOT_W, SLOT_W));
    play_plan();
    a = rand_frame(SLOT_W, SLOT_W);
    send_slot(1'b0, a.l, 13);
    tick(3);
    check("mid_pre_locked", 32'(rx_locked), 1);
    check("mid_pre_overrun", 32'(overrun), 1);
    rst = 1'b1;
    tick(1);
    check_zero_outputs("mid_rst");
    rst = 1'b0;
    clear_model();
    out_ready = 1'b1;
    for (int i = 13; i < SLOT_W; i++) send_bit(1'b0, 1'($urandom()));
    send_slot(1'b1, a.r, SLOT_W);
    plan.push_back(rand_frame(SLOT_W, SLOT_W));
    play_plan();
    tail();
    compare_pairs("mid_post");

`ifdef KOSEI_I2S_RX_STATS_EN
    // Statistics: five good frames, two bad slots
    do_reset();
    out_ready = 1'b1;
    preamble();
    for (int i = 0; i < 7; i++)
      plan.push_back(rand_frame((i == 1) ? SLOT_W - 1 : SLOT_W, (i == 4) ? SLOT_W + 1 : SLOT_W));
    play_plan();
    tail();
    compare_pairs("stat");
    check("stat_frames", 32'(stat_frames), exp_good);
    check("stat_errors", 32'(stat_errors), exp_errs);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
